// File: rtl/axi_burst_pkg.sv
// Shared AXI burst constants and read-FSM state encoding for the BRAM fill
// and drain burst masters.
package axi_burst_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bytes-to-beats shift for 8-byte beats
  localparam int BEAT_SHIFT = 3;

  localparam logic [1:0] RD_STATE_IDLE = 2'd0;
  localparam logic [1:0] RD_STATE_ADDR = 2'd1;
  localparam logic [1:0] RD_STATE_DATA = 2'd2;

  typedef enum logic [1:0] {
    RD_IDLE = RD_STATE_IDLE,
    RD_ADDR = RD_STATE_ADDR,
    RD_DATA = RD_STATE_DATA
  } rd_state_e;

  function automatic logic [6:0] beats_of(input logic [9:0] byte_length);
    return 7'(byte_length >> BEAT_SHIFT);
  endfunction

endpackage

// File: rtl/axi_read_burst_to_bram_if.sv
// AXI4 read address and read data channel bundle used by the BRAM fill master.
interface axi_read_burst_to_bram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rlast;
  logic                  rready;

  modport master (
    output araddr, arprot, arvalid, arlen, arsize, arburst, arlock, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arprot, arvalid, arlen, arsize, arburst, arlock, rready,
    output arready, rdata, rresp, rvalid, rlast
  );

endinterface

// File: rtl/axi_read_burst_to_bram.sv
// AXI4 INCR read-burst master: fetches up to 127 64-bit beats and writes them
// into a local BRAM at consecutive word indices, with busy/done/error status.
module axi_read_burst_to_bram
  import axi_burst_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  axi_read_burst_to_bram_if.master      m_axi,
  input  logic                          run,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr,
  input  logic [9:0]                    byte_length,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          bram_write_enable,
  output logic [9:0]                    bram_write_index,
  output logic [C_M_AXI_DATA_WIDTH-1:0] bram_write_data
);

  rd_state_e state_q, state_d;

  logic [6:0]                    req_beats;
  logic                          accept_run;
  logic                          beat_fire;
  logic                          last_beat;
  logic                          resp_err;
  logic [6:0]                    beat_cnt_q;
  logic [9:0]                    write_idx_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                    arlen_q;
  logic                          error_q;
  logic                          done_q;
  logic                          bram_we_q;
  logic [9:0]                    bram_idx_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] bram_data_q;

  assign req_beats = beats_of(byte_length);
  assign resp_err  = (m_axi.rresp == RESP_SLVERR) || (m_axi.rresp == RESP_DECERR);

  always_comb begin
    state_d    = state_q;
    accept_run = 1'b0;
    beat_fire  = 1'b0;
    last_beat  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (run && (req_beats != 7'd0)) begin
          accept_run = 1'b1;
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_axi.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        // rready is high for the whole of DATA, so rvalid alone is a handshake
        if (m_axi.rvalid) begin
          beat_fire = 1'b1;
          if ((beat_cnt_q == 7'd0) || m_axi.rlast) begin
            last_beat = 1'b1;
            state_d   = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state_q <= RD_IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      araddr_q    <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      write_idx_q <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_idx_q  <= '0;
      bram_data_q <= '0;
    end else begin
      bram_we_q <= beat_fire;
      done_q    <= last_beat;
      if (accept_run) begin
        araddr_q    <= start_addr;
        arlen_q     <= {1'b0, req_beats - 7'd1};
        beat_cnt_q  <= req_beats - 7'd1;
        write_idx_q <= '0;
        error_q     <= 1'b0;
      end
      if (beat_fire) begin
        bram_idx_q  <= write_idx_q;
        bram_data_q <= m_axi.rdata;
        write_idx_q <= write_idx_q + 10'd1;
        if (!last_beat) beat_cnt_q <= beat_cnt_q - 7'd1;
        if (resp_err) error_q <= 1'b1;
        // An rlast that disagrees with our own count is a protocol error
        if (last_beat && (m_axi.rlast != (beat_cnt_q == 7'd0))) error_q <= 1'b1;
      end
    end
  end

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arsize  = SIZE_8B;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arvalid = (state_q == RD_ADDR);
  assign m_axi.rready  = (state_q == RD_DATA);

  assign busy              = (state_q != RD_IDLE);
  assign done              = done_q;
  assign error             = error_q;
  assign bram_write_enable = bram_we_q;
  assign bram_write_index  = bram_idx_q;
  assign bram_write_data   = bram_data_q;

endmodule

// File: tb/tb_axi_read_burst_to_bram.sv
// Directed bench for the AXI read-burst BRAM fill master: table of bursts with
// hand-computed expectations, plus a mid-burst reset sequence.
module tb_axi_read_burst_to_bram;
  import axi_burst_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] start_addr;
  logic [9:0]  byte_length;
  logic        busy, done, error;
  logic        bram_we;
  logic [9:0]  bram_idx;
  logic [63:0] bram_data;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi_read_burst_to_bram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

  axi_read_burst_to_bram #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(64)
  ) dut (
    .m_axi_aclk        (clk),
    .m_axi_aresetn     (rst_n),
    .m_axi             (axi),
    .run               (run),
    .start_addr        (start_addr),
    .byte_length       (byte_length),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .bram_write_enable (bram_we),
    .bram_write_index  (bram_idx),
    .bram_write_data   (bram_data)
  );

  // rlast_at: 0 = on the final beat, -1 = never, n = on beat n
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [9:0]  byte_len;
    int          rlast_at;
    int          err_at;
    logic [1:0]  err_resp;
    bit          gaps;
    int          ar_delay;
    logic [7:0]  exp_arlen;
    int          exp_writes;
    bit          exp_error;
  } vec_t;

  vec_t vecs[$];

  logic [73:0] write_log[$];
  int          done_count = 0;

  // Every BRAM write and done pulse is logged on the falling edge
  always @(negedge clk) begin
    if (bram_we) write_log.push_back({bram_idx, bram_data});
    if (done) done_count++;
  end

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int b);
    return {addr + 32'(8 * (b - 1)), 32'hC0DE_0000 | 32'(b)};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " ar ctrl"}, {axi.arvalid, axi.rready, axi.arprot, axi.arlock},
                {1'b0, 1'b0, 3'b000, 1'b0});
    checkOutput({tag, " araddr/arlen"}, {axi.araddr, axi.arlen}, 40'd0);
    checkOutput({tag, " arsize/arburst"}, {axi.arsize, axi.arburst}, {3'b011, 2'b01});
    checkOutput({tag, " status"}, {busy, done, error}, 3'b000);
    checkOutput({tag, " bram port"}, {bram_we, bram_idx, bram_data}, 75'd0);
  endtask

  task automatic do_request(input vec_t v);
    run         = 1'b1;
    start_addr  = v.addr;
    byte_length = v.byte_len;
    tick();
    run         = 1'b0;
    start_addr  = 32'hDEAD_BEEF;
    byte_length = 10'h3FF;
    checkOutput({v.name, " busy/arvalid"}, {busy, axi.arvalid}, 2'b11);
    checkOutput({v.name, " araddr"}, axi.araddr, v.addr);
    checkOutput({v.name, " arlen"}, axi.arlen, v.exp_arlen);
    checkOutput({v.name, " error cleared"}, error, 1'b0);
  endtask

  task automatic do_addr(input vec_t v);
    // A run during ADDR must not disturb the latched request
    for (int i = 0; i < v.ar_delay; i++) begin
      run = 1'b1;
      tick();
      checkOutput({v.name, " addr hold"}, {axi.arvalid, axi.araddr, axi.arlen},
                  {1'b1, v.addr, v.exp_arlen});
    end
    run         = 1'b0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    checkOutput({v.name, " rready after ar"}, {axi.rready, axi.arvalid}, 2'b10);
  endtask

  task automatic send_beats(input vec_t v, input int count);
    int  beats_n = int'(v.byte_len >> 3);
    int  b       = 1;
    int  budget  = 0;
    bit  fire;
    while ((b <= count) && (budget < 2000)) begin
      if (v.gaps && ($urandom_range(0, 2) == 0)) begin
        axi.rvalid = 1'b0;
      end else begin
        axi.rvalid = 1'b1;
        axi.rdata  = beat_data(v.addr, b);
        axi.rresp  = (b == v.err_at) ? v.err_resp : RESP_OKAY;
        axi.rlast  = (v.rlast_at == 0) ? (b == beats_n) : (b == v.rlast_at);
      end
      fire = axi.rvalid && axi.rready;
      tick();
      if (fire) b++;
      budget++;
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = RESP_OKAY;
    if (b <= count) checkOutput({v.name, " beat budget"}, b, count + 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int log_base  = write_log.size();
    int done_base = done_count;
    if (v.exp_writes == 0) begin
      run         = 1'b1;
      start_addr  = v.addr;
      byte_length = v.byte_len;
      tick();
      run = 1'b0;
      checkOutput({v.name, " ignored"}, {busy, axi.arvalid}, 2'b00);
      repeat (3) tick();
      checkOutput({v.name, " still idle"}, {busy, axi.arvalid, error}, {2'b00, v.exp_error});
      checkOutput({v.name, " no done"}, done_count - done_base, 0);
      return;
    end
    do_request(v);
    do_addr(v);
    send_beats(v, v.exp_writes);
    checkOutput({v.name, " end done/busy/we/rready"}, {done, busy, bram_we, axi.rready},
                4'b1010);
    tick();
    checkOutput({v.name, " done one cycle"}, {done, bram_we}, 2'b00);
    checkOutput({v.name, " error"}, error, v.exp_error);
    checkOutput({v.name, " write count"}, write_log.size() - log_base, v.exp_writes);
    checkOutput({v.name, " done count"}, done_count - done_base, 1);
    for (int k = 0; k < v.exp_writes && (log_base + k) < write_log.size(); k++)
      checkOutput($sformatf("%s write %0d", v.name, k), write_log[log_base + k],
                  {10'(k), beat_data(v.addr, k + 1)});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    rst_n       = 1'b0;
    run         = 1'b0;
    start_addr  = '0;
    byte_length = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = RESP_OKAY;
    axi.rlast   = 1'b0;

    //                name           addr          len     rlast err  resp          gaps ard arlen  wr  err
    vecs.push_back('{"burst8",     32'h0000_1000, 10'd64,   0,  0, RESP_OKAY,    0,   2, 8'd7,   8,  0});
    vecs.push_back('{"single",     32'h0000_2000, 10'd8,    0,  0, RESP_OKAY,    0,   0, 8'd0,   1,  0});
    vecs.push_back('{"len5",       32'h0000_2100, 10'd5,    0,  0, RESP_OKAY,    0,   0, 8'd0,   0,  0});
    vecs.push_back('{"len0",       32'h0000_2200, 10'd0,    0,  0, RESP_OKAY,    0,   0, 8'd0,   0,  0});
    vecs.push_back('{"gaps16",     32'h0000_3000, 10'd128,  0,  3, RESP_SLVERR,  1,   1, 8'd15,  16, 1});
    vecs.push_back('{"len7 sticky",32'h0000_3100, 10'd7,    0,  0, RESP_OKAY,    0,   0, 8'd0,   0,  1});
    vecs.push_back('{"early rlast",32'h0000_4000, 10'd32,   2,  0, RESP_OKAY,    0,   1, 8'd3,   2,  1});
    vecs.push_back('{"no rlast",   32'h0000_5000, 10'd32,  -1,  0, RESP_OKAY,    0,   0, 8'd3,   4,  1});
    vecs.push_back('{"decerr",     32'h0000_6000, 10'd24,   0,  1, RESP_DECERR,  0,   0, 8'd2,   3,  1});
    vecs.push_back('{"exokay",     32'h0000_6100, 10'd16,   0,  2, 2'b01,        0,   0, 8'd1,   2,  0});
    vecs.push_back('{"max127",     32'h0001_0000, 10'd1023, 0,  0, RESP_OKAY,    0,   3, 8'd126, 127,0});

    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset lands in the middle of a 10-beat burst, right after beat 5
    rv = '{"rst mid", 32'h0000_8000, 10'd80, 0, 0, RESP_OKAY, 0, 0, 8'd9, 10, 0};
    do_request(rv);
    do_addr(rv);
    send_beats(rv, 5);
    checkOutput("rst mid busy before reset", {busy, bram_we}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid-burst reset");
    #10;
    rst_n = 1'b1;
    tick();
    applyStimulus('{"after reset", 32'h0000_9000, 10'd24, 0, 0, RESP_OKAY, 0, 1, 8'd2, 3, 0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
